// File: rtl/data_mem_pipelined.sv
// data_mem_pipelined: big-endian byte-addressed MEM-stage data memory
// with self-clearing storage and a programmable-latency response pipe.
module data_mem_pipelined #(
    parameter int WORD_LEN  = 32,
    parameter int MEM_SIZE  = 1024,
    parameter int BASE_ADDR = 1024,
    parameter int READ_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [WORD_LEN-1:0] address,
    input  logic [WORD_LEN-1:0] dataIn,
    output logic                resp_valid,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] dataOut
);
    localparam int NWORDS = MEM_SIZE / 4;
    localparam int AW     = $clog2(NWORDS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       clr_idx;
    logic                clr_last;
    logic [WORD_LEN-1:0] mem [NWORDS];

    logic [WORD_LEN-1:0] off;
    logic [WORD_LEN:0]   end_off;
    logic [2:0]          nbytes;
    logic                err;
    logic                accept;
    logic                store_en;
    logic [AW-1:0]       widx;
    logic [1:0]          lane;
    logic [3:0]          be;
    logic [WORD_LEN-1:0] wd;
    logic [WORD_LEN-1:0] rd_word;
    logic [7:0]          rbyte;
    logic [15:0]         rhalf;
    logic [WORD_LEN-1:0] ld;

    logic                pv [READ_LAT];
    logic                pe [READ_LAT];
    logic [WORD_LEN-1:0] pd [READ_LAT];

    assign clr_last = (clr_idx == AW'(NWORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        unique case (state)
            CLEAR: if (clr_last) state_nxt = READY;
            READY: req_ready = 1'b1;
            default: state_nxt = CLEAR;
        endcase
    end

    // Range check is done one bit wider so huge offsets cannot wrap.
    always_comb begin
        off    = address - WORD_LEN'(BASE_ADDR);
        nbytes = 3'd4;
        unique case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        end_off = {1'b0, off} + (WORD_LEN + 1)'(nbytes);
        err = (address < WORD_LEN'(BASE_ADDR))
            || (end_off > (WORD_LEN + 1)'(MEM_SIZE))
            || (req_size == 2'b11)
            || (req_size == 2'b01 && off[0])
            || (req_size == 2'b10 && off[1:0] != 2'b00);
        widx = off[AW+1:2];
        lane = off[1:0];
    end

    assign accept   = req_valid & req_ready;
    assign store_en = accept & req_write & ~err;

    // Lane 3 holds the lowest-addressed byte (big-endian).
    always_comb begin
        rd_word = mem[widx];
        rbyte   = 8'(rd_word >> {~lane, 3'b000});
        rhalf   = off[1] ? rd_word[15:0] : rd_word[31:16];
        be      = 4'b0000;
        wd      = '0;
        ld      = '0;
        unique case (req_size)
            2'b00: begin
                be = 4'b1000 >> lane;
                wd = {4{dataIn[7:0]}};
                ld = req_signed ? {{(WORD_LEN-8){rbyte[7]}}, rbyte}
                                : {{(WORD_LEN-8){1'b0}}, rbyte};
            end
            2'b01: begin
                be = off[1] ? 4'b0011 : 4'b1100;
                wd = {2{dataIn[15:0]}};
                ld = req_signed ? {{(WORD_LEN-16){rhalf[15]}}, rhalf}
                                : {{(WORD_LEN-16){1'b0}}, rhalf};
            end
            default: begin
                be = 4'b1111;
                wd = dataIn;
                ld = rd_word;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (!rst && store_en) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pv[i] <= 1'b0;
                pe[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= accept & err;
            pd[0] <= (accept & ~req_write & ~err) ? ld : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign resp_valid = pv[READ_LAT-1];
    assign resp_err   = pe[READ_LAT-1];
    assign dataOut    = pd[READ_LAT-1];
endmodule
